memory_level_fsm: RTL and testbench
===================================

# memory_level_fsm

Parametrised level controller for the memory game. It holds a SEQ_LEN-entry sequence of SYM_W-bit symbols, checks the player's entries one per accepted input, and tracks position, combo streak and remaining lives. It reports the round outcome as win or lose. It sits between the input/debounce logic and the display/score logic, and replaces the fixed 16-step, 1-bit, no-lives level FSMs.

## Interface
Parameters:
- SEQ_LEN, 16: number of symbols per round; legal range 2..64.
- SYM_W, 1: symbol width in bits; legal range 1..8.
- LIVES, 3: lives at round start; legal range 1..15.
- SEQ_INIT, 16'b1001011010101011: fixed sequence, SEQ_LEN*SYM_W bits wide. Element i = SEQ_INIT[(SEQ_LEN-1-i)*SYM_W +: SYM_W], so element 0 is at the MSBs.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: clock enable. While 0, all state and outputs hold, and start/in_valid are ignored.
- start, in, 1: begin or restart a round.
- seed, in, 16: LFSR seed, sampled on the accepted start edge.
- in_valid, in, 1: a player entry is present this cycle.
- in_sym, in, SYM_W: the player's symbol.
- seq, out, SEQ_LEN*SYM_W: current sequence, same element ordering as SEQ_INIT.
- pos, out, $clog2(SEQ_LEN): index of the next expected element.
- state_o, out, 2: 0=IDLE, 1=GEN, 2=PLAY, 3=DONE.
- hit, out, 1: one-cycle pulse for a correct entry.
- miss, out, 1: one-cycle pulse for a wrong entry.
- combo, out, 8: consecutive correct entries, saturating at 255.
- lives, out, 4: remaining lives.
- win, out, 1: level; round completed.
- lose, out, 1: level; lives exhausted.

## Operation
- Reset values:
  - state IDLE; pos 0; combo 0; lives LIVES.
  - hit, miss, win, lose all 0.
  - seq = SEQ_INIT.
- IDLE or DONE, start=1:
  - pos←0, combo←0, lives←LIVES, win←0, lose←0.
  - Next state is GEN (macro defined) or PLAY (macro undefined).
- GEN:
  - Writes one element per enabled cycle, element 0 first.
  - Element value is lfsr[SYM_W-1:0]; the LFSR then steps.
  - After element SEQ_LEN-1 is written, next state is PLAY.
  - start and in_valid are ignored in GEN.
- PLAY, in_valid=1, in_sym equals element pos (hit):
  - hit←1; combo←min(combo+1, 255).
  - If pos = SEQ_LEN-1: win←1, pos←0, state DONE.
  - Otherwise pos←pos+1.
- PLAY, in_valid=1, mismatch (miss):
  - miss←1; combo←0; lives←lives-1; pos unchanged.
  - If lives becomes 0: lose←1, state DONE.
- PLAY, start=1: restarts the round exactly as from IDLE. start has priority over a simultaneous in_valid, which is dropped.
- DONE: in_valid is ignored; win, lose, combo and lives hold until start or reset.
- hit and miss are never high together and are 0 in every cycle without a counted entry.

## Timing
- in_valid is sampled at the posedge with en=1. hit/miss, pos, combo, lives, win/lose and state_o update at that same edge, so the response is visible one cycle after the entry.
- Back-to-back entries on consecutive cycles are all accepted; there is no backpressure.
- GEN takes exactly SEQ_LEN enabled cycles. PLAY is entered SEQ_LEN+1 enabled edges after start.
- seq bits update during GEN as each element is written.
- Reset at any point, including mid-GEN or mid-PLAY, restores all reset values at the next edge.

## Configuration
- Macro: MEMGAME_LFSR_EN.
- Defined:
  - Sequence is generated per round by a 16-bit Galois LFSR with taps mask 16'hB400, loaded from seed on start.
  - seed=0 is replaced by 16'hACE1.
  - The same seed always yields the same sequence.
- Undefined:
  - No LFSR and no GEN state; state_o never reads 1.
  - seq is always SEQ_INIT, and start goes directly to PLAY.

## Test plan
- Defaults, macro off: start, then enter 1,0,0,1,0,1,1,0,1,0,1,0,1,0,1,1 on consecutive cycles -> 16 hit pulses, combo=16, lives=3, win=1, state_o=3.
- At pos 0 enter 0 -> miss=1, lives=2, combo=0, pos=0. Next enter 1 -> hit=1, pos=1, combo=1.
- Three wrong entries -> lives 3→2→1→0, lose=1, state_o=3. A further in_valid gives no hit/miss and no change.
- en=0 with in_valid=1 and in_sym correct for 5 cycles -> pos, combo, hit, miss unchanged. Raise en -> accepted next edge.
- Reset at pos=5, combo=5, lives=2 -> next cycle pos=0, combo=0, lives=3, state_o=0, seq=SEQ_INIT.
- Macro on, SYM_W=2, SEQ_LEN=8, seed=0:
  - state_o=1 for exactly 8 cycles; in_valid during GEN ignored.
  - seq matches the LFSR model seeded 16'hACE1.
  - Repeating the same start/seed gives an identical seq.

Source files
------------

// File: rtl/memory_level_fsm.sv
// Memory-game level controller: holds the symbol sequence, scores player entries,
// tracks position/combo/lives. Optional LFSR sequence generation via MEMGAME_LFSR_EN.
module memory_level_fsm #(
  parameter int unsigned SEQ_LEN = 16,
  parameter int unsigned SYM_W   = 1,
  parameter int unsigned LIVES   = 3,
  parameter logic [SEQ_LEN*SYM_W-1:0] SEQ_INIT = 16'b1001011010101011
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         start,
  input  logic [15:0]                  seed,
  input  logic                         in_valid,
  input  logic [SYM_W-1:0]             in_sym,
  output logic [SEQ_LEN*SYM_W-1:0]     seq,
  output logic [$clog2(SEQ_LEN)-1:0]   pos,
  output logic [1:0]                   state_o,
  output logic                         hit,
  output logic                         miss,
  output logic [7:0]                   combo,
  output logic [3:0]                   lives,
  output logic                         win,
  output logic                         lose
);

  localparam int unsigned POS_W = $clog2(SEQ_LEN);
  localparam int unsigned SEQ_W = SEQ_LEN * SYM_W;
  localparam logic [POS_W-1:0] LAST = POS_W'(SEQ_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_d;
  logic [POS_W-1:0] pos_d;
  logic [7:0]       combo_d;
  logic [3:0]       lives_d;
  logic             win_d, lose_d, hit_d, miss_d;
  logic [SEQ_W-1:0] seq_d;
  logic [SYM_W-1:0] exp_sym;
  logic             restart;

`ifdef MEMGAME_LFSR_EN
  logic [15:0] lfsr, lfsr_d;
`else
  logic unused_seed;
  assign unused_seed = ^seed;
`endif

  // Element currently expected from the player
  always_comb begin
    exp_sym = '0;
    for (int i = 0; i < int'(SEQ_LEN); i++) begin
      if (POS_W'(i) == pos) exp_sym = seq[(SEQ_LEN-1-i)*SYM_W +: SYM_W];
    end
  end

  // GEN ignores start so a generated sequence is never left half-written
  assign restart = start && (state_o != S_GEN);

  always_comb begin
    state_d = state_o;
    pos_d   = pos;
    combo_d = combo;
    lives_d = lives;
    win_d   = win;
    lose_d  = lose;
    seq_d   = seq;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
`ifdef MEMGAME_LFSR_EN
    lfsr_d  = lfsr;
`endif
    if (restart) begin
      pos_d   = '0;
      combo_d = 8'd0;
      lives_d = 4'(LIVES);
      win_d   = 1'b0;
      lose_d  = 1'b0;
`ifdef MEMGAME_LFSR_EN
      lfsr_d  = (seed == 16'h0000) ? 16'hACE1 : seed;
      state_d = S_GEN;
`else
      state_d = S_PLAY;
`endif
    end else begin
      case (state_o)
`ifdef MEMGAME_LFSR_EN
        S_GEN: begin
          // pos doubles as the write index while generating
          for (int i = 0; i < int'(SEQ_LEN); i++) begin
            if (POS_W'(i) == pos) seq_d[(SEQ_LEN-1-i)*SYM_W +: SYM_W] = lfsr[SYM_W-1:0];
          end
          lfsr_d = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
          if (pos == LAST) begin
            pos_d   = '0;
            state_d = S_PLAY;
          end else begin
            pos_d = pos + POS_W'(1);
          end
        end
`endif
        S_PLAY: begin
          if (in_valid) begin
            if (in_sym == exp_sym) begin
              hit_d   = 1'b1;
              combo_d = (combo == 8'hFF) ? combo : combo + 8'd1;
              if (pos == LAST) begin
                win_d   = 1'b1;
                pos_d   = '0;
                state_d = S_DONE;
              end else begin
                pos_d = pos + POS_W'(1);
              end
            end else begin
              miss_d  = 1'b1;
              combo_d = 8'd0;
              lives_d = lives - 4'd1;
              if (lives == 4'd1) begin
                lose_d  = 1'b1;
                state_d = S_DONE;
              end
            end
          end
        end
        S_IDLE, S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_o <= S_IDLE;
      pos     <= '0;
      combo   <= 8'd0;
      lives   <= 4'(LIVES);
      win     <= 1'b0;
      lose    <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      seq     <= SEQ_INIT;
`ifdef MEMGAME_LFSR_EN
      lfsr    <= 16'hACE1;
`endif
    end else if (en) begin
      state_o <= state_d;
      pos     <= pos_d;
      combo   <= combo_d;
      lives   <= lives_d;
      win     <= win_d;
      lose    <= lose_d;
      hit     <= hit_d;
      miss    <= miss_d;
      seq     <= seq_d;
`ifdef MEMGAME_LFSR_EN
      lfsr    <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_memory_level_fsm.sv
// Directed bench for memory_level_fsm; covers the LFSR build when MEMGAME_LFSR_EN is set.
module tb_memory_level_fsm;

  localparam logic [15:0] SEQ_INIT_C = 16'b1001011010101011;
`ifdef MEMGAME_LFSR_EN
  localparam int GEN_ON = 1;
`else
  localparam int GEN_ON = 0;
`endif

  typedef struct packed {
    logic       v;
    logic       sym;
    logic       hit;
    logic       miss;
    logic [3:0] pos;
    logic [7:0] combo;
    logic [3:0] lives;
    logic       win;
    logic       lose;
    logic [1:0] st;
  } vec_t;

  logic clk = 1'b0;
  logic reset, en, start, in_valid;
  logic [15:0] seed;
  logic in_sym;
  logic [15:0] seq;
  logic [3:0] pos;
  logic [1:0] state_o;
  logic hit, miss, win, lose;
  logic [7:0] combo;
  logic [3:0] lives;

  logic [1:0]  in_sym2;
  logic [15:0] seq2;
  logic [2:0]  pos2;
  logic [1:0]  st2;
  logic hit2, miss2, win2, lose2;
  logic [7:0] combo2;
  logic [3:0] lives2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  memory_level_fsm u_dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .seed(seed),
    .in_valid(in_valid), .in_sym(in_sym), .seq(seq), .pos(pos), .state_o(state_o),
    .hit(hit), .miss(miss), .combo(combo), .lives(lives), .win(win), .lose(lose)
  );

  memory_level_fsm #(.SEQ_LEN(8), .SYM_W(2), .LIVES(3), .SEQ_INIT(16'h1B6C)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .start(start), .seed(seed),
    .in_valid(in_valid), .in_sym(in_sym2), .seq(seq2), .pos(pos2), .state_o(st2),
    .hit(hit2), .miss(miss2), .combo(combo2), .lives(lives2), .win(win2), .lose(lose2)
  );

  function automatic logic [15:0] model_seq(input int len, input int w, input logic [15:0] sd);
    logic [15:0] s, r;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    r = 16'h0000;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < w; b++) r[(len-1-i)*w + b] = s[b];
      s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gen(output int cnt);
    cnt = 0;
    while (state_o == 2'd1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_start(input string nm);
    int cnt;
    en = 1'b1; in_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_gen(cnt);
    check({nm, ".gen_cycles"}, 32'(cnt), 32'(GEN_ON * 16));
    check({nm, ".state"}, 32'(state_o), 32'd2);
    check({nm, ".pos"}, 32'(pos), 32'd0);
    check({nm, ".lives"}, 32'(lives), 32'd3);
    check({nm, ".winlose"}, {30'd0, win, lose}, 32'd0);
  endtask

  task automatic apply_vec(input string nm, input int idx, input vec_t v);
    string t;
    t = $sformatf("%s[%0d]", nm, idx);
    in_valid = v.v; in_sym = v.sym;
    tick();
    check({t, ".hit"},   32'(hit),     32'(v.hit));
    check({t, ".miss"},  32'(miss),    32'(v.miss));
    check({t, ".pos"},   32'(pos),     32'(v.pos));
    check({t, ".combo"}, 32'(combo),   32'(v.combo));
    check({t, ".lives"}, 32'(lives),   32'(v.lives));
    check({t, ".win"},   32'(win),     32'(v.win));
    check({t, ".lose"},  32'(lose),    32'(v.lose));
    check({t, ".state"}, 32'(state_o), 32'(v.st));
  endtask

  initial begin
    vec_t win_tbl[16];
    vec_t miss_tbl[5];
    logic [15:0] exp_seq, exp_seq2, first_seq2;
    logic e0, e1, e2, e3;
    int cnt;

    exp_seq = GEN_ON ? model_seq(16, 1, 16'h0000) : SEQ_INIT_C;
    e0 = exp_seq[15]; e1 = exp_seq[14]; e2 = exp_seq[13]; e3 = exp_seq[12];

    for (int i = 0; i < 16; i++) begin
      win_tbl[i] = '{v: 1'b1, sym: exp_seq[15-i], hit: 1'b1, miss: 1'b0,
                     pos: 4'((i + 1) % 16), combo: 8'(i + 1), lives: 4'd3,
                     win: (i == 15), lose: 1'b0, st: (i == 15) ? 2'd3 : 2'd2};
    end
    miss_tbl[0] = '{1'b1, ~e0, 1'b0, 1'b1, 4'd0, 8'd0, 4'd2, 1'b0, 1'b0, 2'd2};
    miss_tbl[1] = '{1'b1,  e0, 1'b1, 1'b0, 4'd1, 8'd1, 4'd2, 1'b0, 1'b0, 2'd2};
    miss_tbl[2] = '{1'b1, ~e1, 1'b0, 1'b1, 4'd1, 8'd0, 4'd1, 1'b0, 1'b0, 2'd2};
    miss_tbl[3] = '{1'b1, ~e1, 1'b0, 1'b1, 4'd1, 8'd0, 4'd0, 1'b0, 1'b1, 2'd3};
    miss_tbl[4] = '{1'b1, ~e1, 1'b0, 1'b0, 4'd1, 8'd0, 4'd0, 1'b0, 1'b1, 2'd3};

    reset = 1'b1; en = 1'b1; start = 1'b0; seed = 16'h0000;
    in_valid = 1'b0; in_sym = 1'b0; in_sym2 = 2'b00;
    tick(); tick();
    check("rst.state", 32'(state_o), 32'd0);
    check("rst.pos",   32'(pos),     32'd0);
    check("rst.combo", 32'(combo),   32'd0);
    check("rst.lives", 32'(lives),   32'd3);
    check("rst.flags", {28'd0, hit, miss, win, lose}, 32'd0);
    check("rst.seq",   32'(seq),     32'(SEQ_INIT_C));
    reset = 1'b0;

    // full winning round, then an ignored entry in DONE
    do_start("win");
    check("win.seq", 32'(seq), 32'(exp_seq));
    for (int i = 0; i < 16; i++) apply_vec("win", i, win_tbl[i]);
    apply_vec("win_done", 0, '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd16, 4'd3, 1'b1, 1'b0, 2'd3});

    // misses down to lose, then restart from DONE
    do_start("miss");
    for (int i = 0; i < 5; i++) apply_vec("miss", i, miss_tbl[i]);
    do_start("restart");
    check("restart.combo", 32'(combo), 32'd0);

    // clock enable hold
    apply_vec("en", 0, '{1'b1, e0, 1'b1, 1'b0, 4'd1, 8'd1, 4'd3, 1'b0, 1'b0, 2'd2});
    apply_vec("en", 1, '{1'b1, e1, 1'b1, 1'b0, 4'd2, 8'd2, 4'd3, 1'b0, 1'b0, 2'd2});
    in_valid = 1'b0;
    tick();
    en = 1'b0; in_valid = 1'b1; in_sym = e2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("en_off[%0d].pos", i),   32'(pos),   32'd2);
      check($sformatf("en_off[%0d].combo", i), 32'(combo), 32'd2);
      check($sformatf("en_off[%0d].hm", i),    {30'd0, hit, miss}, 32'd0);
    end
    en = 1'b1;
    tick();
    check("en_on.hit", 32'(hit), 32'd1);
    check("en_on.pos", 32'(pos), 32'd3);
    check("en_on.combo", 32'(combo), 32'd3);

    // start beats a simultaneous correct entry
    start = 1'b1; in_valid = 1'b1; in_sym = e3;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("prio.pos", 32'(pos), 32'd0);
    check("prio.combo", 32'(combo), 32'd0);
    check("prio.hm", {30'd0, hit, miss}, 32'd0);
    check("prio.lives", 32'(lives), 32'd3);
    wait_gen(cnt);
    check("prio.state", 32'(state_o), 32'd2);

    // mid-round reset
    do_start("rstmid");
    in_valid = 1'b1; in_sym = ~e0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_sym = exp_seq[15-i];
      tick();
    end
    in_valid = 1'b0;
    check("rstmid.pre_pos", 32'(pos), 32'd5);
    check("rstmid.pre_combo", 32'(combo), 32'd5);
    check("rstmid.pre_lives", 32'(lives), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid.pos",   32'(pos),     32'd0);
    check("rstmid.combo", 32'(combo),   32'd0);
    check("rstmid.lives", 32'(lives),   32'd3);
    check("rstmid.state", 32'(state_o), 32'd0);
    check("rstmid.seq",   32'(seq),     32'(SEQ_INIT_C));

    // 8x2 instance: GEN length, ignored entries, LFSR contents, repeatability
    exp_seq2 = GEN_ON ? model_seq(8, 2, 16'h0000) : 16'h1B6C;
    seed = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_sym2 = 2'b01;
    cnt = 0;
    while (st2 == 2'd1 && cnt < 100) begin
      check($sformatf("gen2[%0d].hm", cnt), {30'd0, hit2, miss2}, 32'd0);
      tick();
      cnt++;
    end
    in_valid = 1'b0;
    check("gen2.cycles", 32'(cnt), 32'(GEN_ON * 8));
    check("gen2.state", 32'(st2), 32'd2);
    check("gen2.pos", 32'(pos2), 32'd0);
    check("gen2.seq", 32'(seq2), 32'(exp_seq2));
    first_seq2 = seq2;
    in_valid = 1'b1; in_sym2 = exp_seq2[15:14];
    tick();
    in_valid = 1'b0;
    check("gen2.hit", 32'(hit2), 32'd1);
    check("gen2.pos1", 32'(pos2), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (st2 == 2'd1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("gen2.repeat", 32'(seq2), 32'(first_seq2));
    seed = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (st2 == 2'd1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("gen2.seed1234", 32'(seq2), GEN_ON ? 32'(model_seq(8, 2, 16'h1234)) : 32'h1B6C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
